// File: rtl/adc0809_scan_sched_if.sv
// Handshake bundle between the ADC0809 scan scheduler, the converter driver
// and the manual-request / result consumers.
interface adc0809_scan_sched_if;
  logic            scan_en;
  logic [7:0]      ch_mask;
  logic            man_req;
  logic [2:0]      man_ch;
  logic            man_ack;
  logic [7:0]      man_data;
  logic            man_err;
  logic            conv_req;
  logic [2:0]      conv_ch;
  logic [7:0]      conv_data;
  logic            conv_done;
  logic [7:0][7:0] scan_data;
  logic            frame_done;
  logic            overrun;
  logic            timeout_err;

  modport master (
    input  scan_en, ch_mask, man_req, man_ch,
    input  conv_data, conv_done,
    output man_ack, man_data, man_err,
    output conv_req, conv_ch,
    output scan_data, frame_done,
    output overrun, timeout_err
  );

  modport slave (
    output scan_en, ch_mask, man_req, man_ch,
    output conv_data, conv_done,
    input  man_ack, man_data, man_err,
    input  conv_req, conv_ch,
    input  scan_data, frame_done,
    input  overrun, timeout_err
  );
endinterface

// File: rtl/adc0809_scan_sched.sv
// Shares one ADC0809 converter between a periodic channel scan and
// on-demand manual conversions; keeps the 8x8 result bank.
module adc0809_scan_sched #(
  parameter int CLK_FRE     = 50,
  parameter int SCAN_FRE    = 1000,
  parameter int TIMEOUT_CYC = 10000
) (
  input logic                  clk,
  input logic                  rst_n,
  adc0809_scan_sched_if.master bus
);

  localparam int PERIOD = CLK_FRE * 1_000_000 / SCAN_FRE;
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] PER_MAX = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STORE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   per_q, per_d;
  logic            pend_q, pend_d;
  logic [7:0]      mask_q, mask_d;
  logic [2:0]      ptr_q, ptr_d;
  logic            man_q, man_d;
  logic [2:0]      ch_q, ch_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      data_q, data_d;
  logic            abort_q, abort_d;
  logic            conv_req_q, conv_req_d;
  logic            man_ack_q, man_ack_d;
  logic [7:0]      man_data_q, man_data_d;
  logic            man_err_q, man_err_d;
  logic [7:0][7:0] scan_q, scan_d;
  logic            frame_done_q, frame_done_d;
  logic            overrun_q, overrun_d;
  logic            tmo_err_q, tmo_err_d;

  logic       tick;
  logic       fin;
  logic       ab;
  logic [2:0] low_ch;
  logic [2:0] nxt_ch;
  logic       nxt_ok;

  // lowest channel of the new mask, next channel above ch_q in the frame
  always_comb begin
    low_ch = 3'd0;
    nxt_ch = 3'd0;
    nxt_ok = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.ch_mask[i]) low_ch = 3'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_ch = 3'(i);
        nxt_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    mask_d       = mask_q;
    ptr_d        = ptr_q;
    man_d        = man_q;
    ch_d         = ch_q;
    tmo_d        = tmo_q;
    data_d       = data_q;
    abort_d      = abort_q;
    conv_req_d   = conv_req_q;
    man_ack_d    = 1'b0;
    man_data_d   = man_data_q;
    man_err_d    = man_err_q;
    scan_d       = scan_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    tmo_err_d    = tmo_err_q;
    fin          = 1'b0;
    ab           = 1'b0;
    tick         = 1'b0;

    if (per_q == PER_MAX) begin
      per_d = '0;
      tick  = bus.scan_en & (|bus.ch_mask);
    end else begin
      per_d = per_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.man_req) begin
          man_d = 1'b1;
          ch_d  = bus.man_ch;
        end else if (pend_q) begin
          man_d = 1'b0;
          ch_d  = ptr_q;
        end
        if (bus.man_req || pend_q) begin
          state_d    = S_ISSUE;
          conv_req_d = 1'b1;
          tmo_d      = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = tmo_q + 1'b1;
      end
      S_WAIT: begin
        if (bus.conv_done) begin
          fin    = 1'b1;
          data_d = bus.conv_data;
        end else if (tmo_q == TMO_MAX) begin
          fin       = 1'b1;
          ab        = 1'b1;
          tmo_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (fin) begin
          state_d    = S_STORE;
          conv_req_d = 1'b0;
          abort_d    = ab;
          // manual result is presented during STORE so the
          // requester can drop man_req before IDLE re-arbitrates
          if (man_q) begin
            man_ack_d  = 1'b1;
            man_err_d  = ab;
            man_data_d = ab ? 8'hFF : bus.conv_data;
          end
        end
      end
      S_STORE: begin
        state_d = S_IDLE;
        if (!man_q) begin
          if (!abort_q) scan_d[ch_q] = data_q;
          if (nxt_ok) begin
            ptr_d = nxt_ch;
          end else begin
            frame_done_d = 1'b1;
            pend_d       = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tick) begin
      if (pend_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        mask_d = bus.ch_mask;
        ptr_d  = low_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      per_q        <= '0;
      pend_q       <= 1'b0;
      mask_q       <= 8'h00;
      ptr_q        <= 3'd0;
      man_q        <= 1'b0;
      ch_q         <= 3'd0;
      tmo_q        <= '0;
      data_q       <= 8'h00;
      abort_q      <= 1'b0;
      conv_req_q   <= 1'b0;
      man_ack_q    <= 1'b0;
      man_data_q   <= 8'h00;
      man_err_q    <= 1'b0;
      scan_q       <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      pend_q       <= pend_d;
      mask_q       <= mask_d;
      ptr_q        <= ptr_d;
      man_q        <= man_d;
      ch_q         <= ch_d;
      tmo_q        <= tmo_d;
      data_q       <= data_d;
      abort_q      <= abort_d;
      conv_req_q   <= conv_req_d;
      man_ack_q    <= man_ack_d;
      man_data_q   <= man_data_d;
      man_err_q    <= man_err_d;
      scan_q       <= scan_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign bus.conv_req    = conv_req_q;
  assign bus.conv_ch     = ch_q;
  assign bus.man_ack     = man_ack_q;
  assign bus.man_data    = man_data_q;
  assign bus.man_err     = man_err_q;
  assign bus.scan_data   = scan_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_adc0809_scan_sched.sv
// Directed bench for adc0809_scan_sched with a behavioural ADC driver
// that answers {5'h0, ch} after a programmable delay.
module tb_adc0809_scan_sched;

  localparam int CLK_FRE  = 1;
  localparam int SCAN_FRE = 500;
  localparam int TMO      = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc0809_scan_sched_if bus();

  adc0809_scan_sched #(
    .CLK_FRE    (CLK_FRE),
    .SCAN_FRE   (SCAN_FRE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int total = 0;
  int bad = 0;

  int frames = 0;
  int acks = 0;
  logic [7:0] ack_data = 8'h00;
  logic ack_err = 1'b0;
  int log_q[$];
  int lens[$];
  int drv_delay = 100;
  int drop_ch = 8;
  logic req_prev = 1'b0;
  int req_len = 0;
  int cnt = 0;
  bit sent = 1'b0;
  int cur_ch = 0;

  // driver model and monitor, sampled 1ns after each rising edge
  initial begin
    bus.conv_done = 1'b0;
    bus.conv_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.conv_done = 1'b0;
      if (bus.frame_done) frames++;
      if (bus.man_ack) begin
        acks++;
        ack_data = bus.man_data;
        ack_err = bus.man_err;
      end
      if (bus.conv_req && !req_prev) begin
        log_q.push_back(int'(bus.conv_ch));
        cur_ch = int'(bus.conv_ch);
        req_len = 0;
        cnt = 0;
        sent = 1'b0;
      end
      if (!bus.conv_req && req_prev) lens.push_back(req_len);
      if (bus.conv_req) begin
        req_len++;
        if (!sent) begin
          cnt++;
          if (cnt >= drv_delay && cur_ch != drop_ch) begin
            bus.conv_done = 1'b1;
            bus.conv_data = 8'(cur_ch);
            sent = 1'b1;
          end
        end
      end
      req_prev = bus.conv_req;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int from);
    logic [63:0] v = 64'h0;
    for (int i = from; i < log_q.size(); i++)
      v = (v << 4) | 64'(log_q[i]);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_frames(input int f0, input int max);
    int k = 0;
    while (frames == f0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("frame_wait", 64'(frames != f0), 64'd1);
  endtask

  task automatic wait_acks(input int a0, input int max);
    int k = 0;
    while (acks == a0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("ack_wait", 64'(acks != a0), 64'd1);
  endtask

  task automatic wait_req(input int ch, input int max);
    int k = 0;
    while (!(bus.conv_req && int'(bus.conv_ch) == ch) && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("req_wait", 64'(bus.conv_req), 64'd1);
  endtask

  typedef struct {
    logic [7:0]  mask;
    int          n;
    logic [63:0] order;
    logic [63:0] scan;
  } vec_t;

  vec_t vt[5];
  int f0, lb, a0, ln;

  initial begin
    vt[0] = '{8'hA5, 4, 64'h0257, 64'h0700050000020000};
    vt[1] = '{8'h01, 1, 64'h0, 64'h0};
    vt[2] = '{8'h80, 1, 64'h7, 64'h0700000000000000};
    vt[3] = '{8'h5A, 4, 64'h1346, 64'h0006000403000100};
    vt[4] = '{8'hFF, 8, 64'h01234567, 64'h0706050403020100};

    bus.scan_en = 1'b0;
    bus.ch_mask = 8'h00;
    bus.man_req = 1'b0;
    bus.man_ch = 3'd0;

    do_reset();
    chk("rst_conv_req", 64'(bus.conv_req), 64'd0);
    chk("rst_man_ack", 64'(bus.man_ack), 64'd0);
    chk("rst_man_data", 64'(bus.man_data), 64'd0);
    chk("rst_scan", bus.scan_data, 64'd0);
    chk("rst_flags", 64'({bus.frame_done, bus.overrun,
                          bus.timeout_err, bus.man_err}), 64'd0);

    for (int v = 0; v < 5; v++) begin
      bus.scan_en = 1'b1;
      bus.ch_mask = vt[v].mask;
      do_reset();
      f0 = frames;
      lb = log_q.size();
      wait_frames(f0, 4000);
      chk($sformatf("v%0d_nconv", v), 64'(log_q.size() - lb), 64'(vt[v].n));
      chk($sformatf("v%0d_order", v), pack(lb), vt[v].order);
      chk($sformatf("v%0d_scan", v), bus.scan_data, vt[v].scan);
      chk($sformatf("v%0d_nframe", v), 64'(frames - f0), 64'd1);
      chk($sformatf("v%0d_overrun", v), 64'(bus.overrun), 64'd0);
    end

    // manual request arrives while scan converts ch 2
    bus.ch_mask = 8'hFF;
    bus.scan_en = 1'b1;
    do_reset();
    f0 = frames;
    lb = log_q.size();
    a0 = acks;
    wait_req(2, 4000);
    bus.man_ch = 3'd3;
    bus.man_req = 1'b1;
    wait_acks(a0, 2000);
    bus.man_req = 1'b0;
    chk("pre_data", 64'(ack_data), 64'h03);
    chk("pre_err", 64'(ack_err), 64'd0);
    wait_frames(f0, 2000);
    chk("pre_order", pack(lb), 64'h012334567);
    chk("pre_scan", bus.scan_data, 64'h0706050403020100);

    // second frame with ch 4 never answering
    do_reset();
    f0 = frames;
    wait_frames(f0, 4000);
    chk("tmo_err_before", 64'(bus.timeout_err), 64'd0);
    drop_ch = 4;
    f0 = frames;
    lb = log_q.size();
    ln = lens.size();
    wait_frames(f0, 5000);
    drop_ch = 8;
    chk("tmo_err", 64'(bus.timeout_err), 64'd1);
    chk("tmo_scan", bus.scan_data, 64'h0706050403020100);
    chk("tmo_order", pack(lb), 64'h01234567);
    chk("tmo_len", 64'(lens.size() > ln + 4 &&
                       lens[ln + 4] >= TMO - 1 &&
                       lens[ln + 4] <= TMO + 1), 64'd1);

    // frame longer than one period
    drv_delay = 300;
    do_reset();
    f0 = frames;
    lb = log_q.size();
    wait_frames(f0, 6000);
    chk("ovr_flag", 64'(bus.overrun), 64'd1);
    chk("ovr_order", pack(lb), 64'h01234567);
    chk("ovr_nframe", 64'(frames - f0), 64'd1);
    drv_delay = 100;

    // scanning disabled: only manual conversions, first one times out
    bus.scan_en = 1'b0;
    bus.ch_mask = 8'hFF;
    drop_ch = 6;
    do_reset();
    lb = log_q.size();
    a0 = acks;
    bus.man_ch = 3'd6;
    bus.man_req = 1'b1;
    wait_acks(a0, 2000);
    bus.man_req = 1'b0;
    chk("man_tmo_err", 64'(ack_err), 64'd1);
    chk("man_tmo_data", 64'(ack_data), 64'hFF);
    chk("man_tmo_flag", 64'(bus.timeout_err), 64'd1);
    repeat (2500) @(negedge clk);
    chk("noscan_conv", 64'(log_q.size() - lb), 64'd1);
    bus.scan_en = 1'b1;
    bus.ch_mask = 8'h00;
    drop_ch = 8;
    a0 = acks;
    bus.man_ch = 3'd1;
    bus.man_req = 1'b1;
    wait_acks(a0, 2000);
    bus.man_req = 1'b0;
    chk("man_data", 64'(ack_data), 64'h01);
    chk("man_err", 64'(ack_err), 64'd0);
    repeat (2100) @(negedge clk);
    chk("nomask_conv", 64'(log_q.size() - lb), 64'd2);
    chk("man_hold", 64'(bus.man_data), 64'h01);

    // reset asserted in the middle of a conversion
    bus.ch_mask = 8'hA5;
    do_reset();
    f0 = frames;
    wait_frames(f0, 4000);
    wait_req(0, 3000);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rwait_conv_req", 64'(bus.conv_req), 64'd0);
    chk("rwait_scan", bus.scan_data, 64'd0);
    chk("rwait_flags", 64'({bus.man_ack, bus.frame_done,
                            bus.overrun, bus.timeout_err}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames;
    lb = log_q.size();
    repeat (1900) @(negedge clk);
    chk("rwait_idle", 64'(log_q.size() - lb), 64'd0);
    wait_frames(f0, 2500);
    chk("rwait_order", pack(lb), 64'h0257);
    chk("rwait_scan2", bus.scan_data, 64'h0700050000020000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
